// File: rtl/regfile_wb_arbiter.sv
// Merges two pipe writebacks and a 2-deep buffered multdiv result onto the two
// registered regfile write ports. Define WBARB_PERF_EN to add wb_kill_count.
module regfile_wb_arbiter (
   input  logic        clock,
   input  logic        ctrl_reset,
   input  logic        wb_valid_a,
   input  logic [4:0]  wb_reg_a,
   input  logic [31:0] wb_data_a,
   input  logic        wb_valid_b,
   input  logic [4:0]  wb_reg_b,
   input  logic [31:0] wb_data_b,
   input  logic        md_valid,
   input  logic [4:0]  md_reg,
   input  logic [31:0] md_data,
   output logic        md_ready,
   output logic        ctrl_writeEnable_a,
   output logic [4:0]  ctrl_writeReg_a,
   output logic [31:0] data_writeReg_a,
   output logic        ctrl_writeEnable_b,
   output logic [4:0]  ctrl_writeReg_b,
   output logic [31:0] data_writeReg_b,
   output logic [1:0]  md_pending
`ifdef WBARB_PERF_EN
   ,
   output logic [15:0] wb_kill_count
`endif
);

   // Handshake: an md entry transfers at a rising edge where md_valid && md_ready;
   // md_ready depends only on the registered fill level, never on this cycle's drains.
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} fifo_state_t;

   fifo_state_t        state, state_nx;
   logic [1:0][4:0]    q_reg, n_reg, s_reg;
   logic [1:0][31:0]   q_data, n_data, s_data;

   logic        pa, pb, supp_a, claim_a, claim_b;
   logic        v0, v1, k0, k1, dup, md_fire, md_hit, md_keep;
   logic [1:0]  s_cnt, free_cnt, n_drain, r_cnt, n_cnt;
   logic        ea_nx, eb_nx;
   logic [4:0]  ra_nx, rb_nx;
   logic [31:0] da_nx, db_nx;

   function automatic logic pipe_hit(input logic [4:0] r, input logic hit_a, input logic hit_b,
                                     input logic [4:0] reg_a, input logic [4:0] reg_b);
      return (hit_a && r == reg_a) || (hit_b && r == reg_b);
   endfunction

   assign md_ready   = (state != FULL);
   assign md_pending = state;

   always_comb begin
      pa      = wb_valid_a && (wb_reg_a != 5'd0);
      pb      = wb_valid_b && (wb_reg_b != 5'd0);
      supp_a  = pa && pb && (wb_reg_a == wb_reg_b);
      claim_a = pa && !supp_a;
      claim_b = pb;

      v0 = (state != EMPTY);
      v1 = (state == FULL);
      k0 = v0 && pipe_hit(q_reg[0], pa, pb, wb_reg_a, wb_reg_b);
      k1 = v1 && pipe_hit(q_reg[1], pa, pb, wb_reg_a, wb_reg_b);

      // Compact surviving entries so slot 0 is always the oldest survivor.
      s_cnt  = 2'd0;
      s_reg  = '0;
      s_data = '0;
      if (v0 && !k0) begin
         s_reg[0]  = q_reg[0];
         s_data[0] = q_data[0];
         s_cnt     = 2'd1;
      end
      if (v1 && !k1) begin
         if (s_cnt == 2'd1) begin
            s_reg[1]  = q_reg[1];
            s_data[1] = q_data[1];
         end else begin
            s_reg[0]  = q_reg[1];
            s_data[0] = q_data[1];
         end
         s_cnt = s_cnt + 2'd1;
      end

      free_cnt = {1'b0, !claim_a} + {1'b0, !claim_b};
      n_drain  = (free_cnt < s_cnt) ? free_cnt : s_cnt;
      dup      = (n_drain == 2'd2) && (s_reg[0] == s_reg[1]);

      ea_nx = claim_a;
      ra_nx = claim_a ? wb_reg_a : 5'd0;
      da_nx = claim_a ? wb_data_a : 32'd0;
      eb_nx = claim_b;
      rb_nx = claim_b ? wb_reg_b : 5'd0;
      db_nx = claim_b ? wb_data_b : 32'd0;
      // The oldest drained entry takes the first free port; a duplicate pair keeps only the younger.
      if (!claim_a && n_drain != 2'd0 && !dup) begin
         ea_nx = 1'b1;
         ra_nx = s_reg[0];
         da_nx = s_data[0];
      end
      if (!claim_b) begin
         if (claim_a && n_drain != 2'd0) begin
            eb_nx = 1'b1;
            rb_nx = s_reg[0];
            db_nx = s_data[0];
         end else if (!claim_a && n_drain == 2'd2) begin
            eb_nx = 1'b1;
            rb_nx = s_reg[1];
            db_nx = s_data[1];
         end
      end

      r_cnt  = s_cnt - n_drain;
      n_reg  = '0;
      n_data = '0;
      if (n_drain == 2'd0) begin
         n_reg  = s_reg;
         n_data = s_data;
      end else if (n_drain == 2'd1) begin
         n_reg[0]  = s_reg[1];
         n_data[0] = s_data[1];
      end

      md_fire = md_valid && md_ready;
      md_hit  = pipe_hit(md_reg, pa, pb, wb_reg_a, wb_reg_b);
      md_keep = md_fire && (md_reg != 5'd0) && !md_hit;
      if (md_keep) begin
         if (r_cnt == 2'd0) begin
            n_reg[0]  = md_reg;
            n_data[0] = md_data;
         end else begin
            n_reg[1]  = md_reg;
            n_data[1] = md_data;
         end
      end
      n_cnt    = r_cnt + {1'b0, md_keep};
      state_nx = fifo_state_t'(n_cnt);
   end

   always_ff @(posedge clock or negedge ctrl_reset) begin
      if (!ctrl_reset) begin
         state              <= EMPTY;
         q_reg              <= '0;
         q_data             <= '0;
         ctrl_writeEnable_a <= 1'b0;
         ctrl_writeReg_a    <= 5'd0;
         data_writeReg_a    <= 32'd0;
         ctrl_writeEnable_b <= 1'b0;
         ctrl_writeReg_b    <= 5'd0;
         data_writeReg_b    <= 32'd0;
      end else begin
         state              <= state_nx;
         q_reg              <= n_reg;
         q_data             <= n_data;
         ctrl_writeEnable_a <= ea_nx;
         ctrl_writeReg_a    <= ra_nx;
         data_writeReg_a    <= da_nx;
         ctrl_writeEnable_b <= eb_nx;
         ctrl_writeReg_b    <= rb_nx;
         data_writeReg_b    <= db_nx;
      end
   end

`ifdef WBARB_PERF_EN
   logic        md_kill;
   logic [2:0]  kill_events;
   logic [16:0] kill_sum;

   always_comb begin
      md_kill     = md_fire && (md_reg != 5'd0) && md_hit;
      kill_events = 3'(supp_a) + 3'(k0) + 3'(k1) + 3'(md_kill) + 3'(dup);
      kill_sum    = {1'b0, wb_kill_count} + 17'(kill_events);
   end

   always_ff @(posedge clock or negedge ctrl_reset) begin
      if (!ctrl_reset) wb_kill_count <= 16'd0;
      else             wb_kill_count <= kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
   end
`else
   // Default build keeps no drop accounting.
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter against a queue-based reference model.
module tb_regfile_wb_arbiter;

   logic        clock = 1'b0;
   logic        ctrl_reset;
   logic        va, vb, mv;
   logic [4:0]  ra, rb, mr;
   logic [31:0] da, db, mdd;
   logic        md_ready;
   logic        ctrl_writeEnable_a, ctrl_writeEnable_b;
   logic [4:0]  ctrl_writeReg_a, ctrl_writeReg_b;
   logic [31:0] data_writeReg_a, data_writeReg_b;
   logic [1:0]  md_pending;
`ifdef WBARB_PERF_EN
   logic [15:0] wb_kill_count;
`endif

   typedef struct packed {
      logic [4:0]  r;
      logic [31:0] d;
   } ent_t;

   ent_t mq[$];
   int   kill_model = 0;
   int   total = 0;
   int   bad = 0;

   always #5 clock = ~clock;

   regfile_wb_arbiter dut (
      .clock(clock), .ctrl_reset(ctrl_reset),
      .wb_valid_a(va), .wb_reg_a(ra), .wb_data_a(da),
      .wb_valid_b(vb), .wb_reg_b(rb), .wb_data_b(db),
      .md_valid(mv), .md_reg(mr), .md_data(mdd), .md_ready(md_ready),
      .ctrl_writeEnable_a(ctrl_writeEnable_a), .ctrl_writeReg_a(ctrl_writeReg_a),
      .data_writeReg_a(data_writeReg_a),
      .ctrl_writeEnable_b(ctrl_writeEnable_b), .ctrl_writeReg_b(ctrl_writeReg_b),
      .data_writeReg_b(data_writeReg_b),
      .md_pending(md_pending)
`ifdef WBARB_PERF_EN
      , .wb_kill_count(wb_kill_count)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic iva, input logic [4:0] ira, input logic [31:0] ida,
                         input logic ivb, input logic [4:0] irb, input logic [31:0] idb,
                         input logic imv, input logic [4:0] imr, input logic [31:0] imd);
      va = iva; ra = ira; da = ida;
      vb = ivb; rb = irb; db = idb;
      mv = imv; mr = imr; mdd = imd;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_en_a"}, {31'b0, ctrl_writeEnable_a}, 32'd0);
      chk({tag, "_reg_a"}, {27'b0, ctrl_writeReg_a}, 32'd0);
      chk({tag, "_dat_a"}, data_writeReg_a, 32'd0);
      chk({tag, "_en_b"}, {31'b0, ctrl_writeEnable_b}, 32'd0);
      chk({tag, "_reg_b"}, {27'b0, ctrl_writeReg_b}, 32'd0);
      chk({tag, "_dat_b"}, data_writeReg_b, 32'd0);
      chk({tag, "_pending"}, {30'b0, md_pending}, 32'd0);
      chk({tag, "_ready"}, {31'b0, md_ready}, 32'd1);
`ifdef WBARB_PERF_EN
      chk({tag, "_kills"}, {16'b0, wb_kill_count}, 32'd0);
`endif
   endtask

   // One clock: predict from the current inputs and model queue, then compare after the edge.
   task automatic step();
      ent_t        keep[$];
      ent_t        got[$];
      ent_t        e;
      int          slots[$];
      int          kills;
      logic        pa, pb, ready, x_ea, x_eb;
      logic [4:0]  x_ra, x_rb;
      logic [31:0] x_da, x_db;

      ready = (mq.size() != 2);
      chk("md_ready", {31'b0, md_ready}, {31'b0, ready});
      kills = 0;
      pa = va && (ra != 5'd0);
      pb = vb && (rb != 5'd0);
      x_eb = pb;
      x_rb = pb ? rb : 5'd0;
      x_db = pb ? db : 32'd0;
      x_ea = pa && !(pb && ra == rb);
      x_ra = x_ea ? ra : 5'd0;
      x_da = x_ea ? da : 32'd0;
      if (pa && pb && ra == rb) kills++;
      foreach (mq[i]) begin
         if ((pa && mq[i].r == ra) || (pb && mq[i].r == rb)) kills++;
         else keep.push_back(mq[i]);
      end
      if (!x_ea) slots.push_back(0);
      if (!x_eb) slots.push_back(1);
      foreach (slots[i]) if (keep.size() > 0) got.push_back(keep.pop_front());
      if (got.size() == 2 && got[0].r == got[1].r) begin
         kills++;
         got[0].r = 5'd0;
      end
      foreach (got[i]) begin
         if (got[i].r != 5'd0) begin
            if (slots[i] == 0) begin x_ea = 1'b1; x_ra = got[i].r; x_da = got[i].d; end
            else begin x_eb = 1'b1; x_rb = got[i].r; x_db = got[i].d; end
         end
      end
      if (mv && ready && mr != 5'd0) begin
         if ((pa && mr == ra) || (pb && mr == rb)) kills++;
         else begin
            e.r = mr;
            e.d = mdd;
            keep.push_back(e);
         end
      end
      mq = keep;
      kill_model = (kill_model + kills > 65535) ? 65535 : kill_model + kills;

      @(posedge clock);
      #1;
      chk("en_a", {31'b0, ctrl_writeEnable_a}, {31'b0, x_ea});
      chk("reg_a", {27'b0, ctrl_writeReg_a}, {27'b0, x_ra});
      chk("dat_a", data_writeReg_a, x_da);
      chk("en_b", {31'b0, ctrl_writeEnable_b}, {31'b0, x_eb});
      chk("reg_b", {27'b0, ctrl_writeReg_b}, {27'b0, x_rb});
      chk("dat_b", data_writeReg_b, x_db);
      chk("pending", {30'b0, md_pending}, mq.size());
      if (ctrl_writeEnable_a && ctrl_writeEnable_b)
         chk("distinct_regs", {31'b0, ctrl_writeReg_a == ctrl_writeReg_b}, 32'd0);
`ifdef WBARB_PERF_EN
      chk("kill_count", {16'b0, wb_kill_count}, kill_model);
`endif
   endtask

   task automatic reset_mid_cycle(input string tag);
      #2;
      ctrl_reset = 1'b0;
      #1;
      mq.delete();
      kill_model = 0;
      chk_idle_outputs(tag);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clock);
      ctrl_reset = 1'b1;
   endtask

   initial begin
      ctrl_reset = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #3;
      chk_idle_outputs("reset");
      @(negedge clock);
      ctrl_reset = 1'b1;

      // Two distinct pipe writes land on their own ports.
      set_in(1, 5'd5, 32'h11, 1, 5'd6, 32'h22, 0, 0, 0);
      step();
      chk("dir026_reg_a", {27'b0, ctrl_writeReg_a}, 32'd5);
      chk("dir026_dat_b", data_writeReg_b, 32'h22);

      // Same register from both pipes: the younger b wins.
      set_in(1, 5'd7, 32'h1, 1, 5'd7, 32'h2, 0, 0, 0);
      step();
      chk("dir027_en_a", {31'b0, ctrl_writeEnable_a}, 32'd0);
      chk("dir027_dat_b", data_writeReg_b, 32'h2);

      // Register 0 writes vanish.
      set_in(1, 5'd0, 32'h33, 1, 5'd0, 32'h44, 0, 0, 0);
      step();

      // Lone multdiv result: buffered one cycle, then port a.
      set_in(0, 0, 0, 0, 0, 0, 1, 5'd9, 32'hAA);
      step();
      chk("dir028_pending1", {30'b0, md_pending}, 32'd1);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk("dir028_reg_a", {27'b0, ctrl_writeReg_a}, 32'd9);
      chk("dir028_pending0", {30'b0, md_pending}, 32'd0);

      // Three offers under busy pipes: two buffered, third refused, then drained in order.
      set_in(1, 5'd1, 32'h100, 1, 5'd2, 32'h200, 1, 5'd10, 32'hA0);
      step();
      set_in(1, 5'd1, 32'h101, 1, 5'd2, 32'h201, 1, 5'd11, 32'hB0);
      step();
      chk("dir029_full", {31'b0, md_ready}, 32'd0);
      set_in(1, 5'd1, 32'h102, 1, 5'd2, 32'h202, 1, 5'd12, 32'hC0);
      step();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk("dir029_order_a", data_writeReg_a, 32'hA0);
      chk("dir029_order_b", data_writeReg_b, 32'hB0);

      // Buffered r3 is overwritten by a pipe write to r3.
      set_in(0, 0, 0, 0, 0, 0, 1, 5'd3, 32'h33);
      step();
      set_in(0, 0, 0, 1, 5'd3, 32'h55, 0, 0, 0);
      step();
      chk("dir030_en_a", {31'b0, ctrl_writeEnable_a}, 32'd0);
      chk("dir030_dat_b", data_writeReg_b, 32'h55);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();

      // Two buffered entries for the same register: only the younger lands.
      set_in(1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 1, 5'd8, 32'h81);
      step();
      set_in(1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 1, 5'd8, 32'h82);
      step();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk("dup_dat_b", data_writeReg_b, 32'h82);

      // Fill the buffer, then reset mid-cycle.
      set_in(1, 5'd4, 32'h4, 1, 5'd5, 32'h5, 1, 5'd20, 32'h20);
      step();
      set_in(1, 5'd4, 32'h4, 1, 5'd5, 32'h5, 1, 5'd21, 32'h21);
      step();
      chk("dir031_full", {30'b0, md_pending}, 32'd2);
      reset_mid_cycle("dir031");
      step();
      step();

      for (int i = 0; i < 400; i++) begin
         set_in($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
         step();
         if (i == 200) reset_mid_cycle("rand_reset");
      end

      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: ctrl_reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: wb_valid_a / wb_reg_a / wb_data_a  in  1/5/32  older pipe writeback.
REQ-004 SHALL have ports: wb_valid_b / wb_reg_b / wb_data_b  in  1/5/32  younger pipe writeback.
REQ-005 SHALL have ports: md_valid / md_reg / md_data  in  1/5/32  multdiv result offer; md_ready  out  1  accept.
REQ-006 SHALL have ports: ctrl_writeEnable_a / ctrl_writeReg_a / data_writeReg_a  out  1/5/32  regfile write port a.
REQ-007 SHALL have ports: ctrl_writeEnable_b / ctrl_writeReg_b / data_writeReg_b  out  1/5/32  regfile write port b.
REQ-008 SHALL have ports: md_pending  out  2  buffered multdiv entry count.

Function
REQ-009 SHALL register all write-port outputs: inputs sampled at edge N drive ports during cycle N+1.
REQ-010 Pipe writebacks SHALL never stall; each valid pipe write with reg!=0 is emitted at its own letter's port.
REQ-011 If both pipe writes valid with equal nonzero reg, SHALL suppress a (b younger wins).
REQ-012 Writes to reg 0 from any source SHALL be discarded, never emitted.
REQ-013 Multdiv transfer SHALL occur when md_valid && md_ready at an edge; entry enters a 2-deep FIFO (state EMPTY/ONE/FULL).
REQ-014 md_ready SHALL equal (md_pending != 2), from registered count only; no enqueue while FULL even if draining that cycle.
REQ-015 Each cycle, ports not claimed by pipe writes SHALL be given to FIFO entries, oldest first, port a before port b, up to two.
REQ-016 An entry enqueued at edge N SHALL be drain-eligible no earlier than edge N+1 (minimum 2-cycle md-to-port latency).
REQ-017 WAW kill: FIFO entry or incoming md transfer whose reg equals a valid pipe reg in that cycle SHALL be dropped, not written.
REQ-018 If two FIFO entries with equal reg drain together, only the younger SHALL be emitted.
REQ-019 Both ports SHALL never be enabled with equal ctrl_writeReg.
REQ-020 FIFO transitions: EMPTY->ONE on enqueue; ONE->FULL enqueue without drain/kill; ONE->EMPTY drain or kill; FULL->ONE one removal; FULL->EMPTY two removals; simultaneous enqueue+removal keeps count.
REQ-021 Disabled ports SHALL drive ctrl_writeReg=0 and data_writeReg=0.

Reset
REQ-022 ctrl_reset low SHALL immediately clear FIFO to EMPTY, both enables 0, regs/data 0, md_pending 0, md_ready 1.
REQ-023 Reset mid-operation SHALL discard buffered entries; first legal write is sampled at first edge after release.

Configuration
REQ-024 Macro WBARB_PERF_EN defined: SHALL add output wb_kill_count (16-bit) counting REQ-011/017/018 drops, saturating at 0xFFFF, reset 0.
REQ-025 Macro WBARB_PERF_EN undefined: port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-026 wb_a valid r5=0x11, wb_b valid r6=0x22 -> next cycle port a r5/0x11, port b r6/0x22.
REQ-027 wb_a r7=0x1, wb_b r7=0x2 -> port a disabled, port b r7/0x2.
REQ-028 md r9=0xAA accepted, no pipe traffic -> port a r9/0xAA two cycles later, md_pending 1->0.
REQ-029 Three md offers while both pipe ports busy -> two accepted, md_ready=0 on third, drained in order once pipes idle.
REQ-030 FIFO holds r3; wb_b writes r3 -> r3 entry dropped, only pipe value written, wb_kill_count +1 when WBARB_PERF_EN.
REQ-031 Assert ctrl_reset low with FIFO FULL -> outputs zero same cycle, md_pending 0, no buffered write after release.
